// File: rtl/stream_rx_gearbox_if.sv
// Write-side stream and read-side show-ahead bus of the 256->64 receive gearbox.
interface stream_rx_gearbox_if;
  logic [255:0] fifo_data;
  logic         fifo_write;
  logic         fifo_send;
  logic         fifo_full;
  logic [63:0]  rd_data;
  logic         rd_read;
  logic         rd_empty;
  logic         pkt_done;
  logic         overflow;
  logic [15:0]  word_count;

  modport master (
    output fifo_data, fifo_write, fifo_send, rd_read,
    input  fifo_full, rd_data, rd_empty, pkt_done, overflow, word_count
  );

  modport slave (
    input  fifo_data, fifo_write, fifo_send, rd_read,
    output fifo_full, rd_data, rd_empty, pkt_done, overflow, word_count
  );
endinterface

// File: rtl/stream_rx_gearbox.sv
// Buffers 256-bit stream entries and emits them as four 64-bit show-ahead words,
// lowest lane first, with packet-end pulse, sticky overflow and consumed-word count.
module stream_rx_gearbox #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  stream_rx_gearbox_if.slave  bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [1:0] {LANE0, LANE1, LANE2, LANE3} lane_t;

  logic [255:0]     r_mem [DEPTH];
  logic             r_tag [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  lane_t            r_lane;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;
  logic             r_pkt_done;
  logic [15:0]      r_word_count;

  logic             w_wr;
  logic             w_rd;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Writes and reads are gated by the registered flags, so a pop never frees
  // a slot for a write in the same cycle.
  assign w_wr  = bus.fifo_write && !r_full;
  assign w_rd  = bus.rd_read && !r_empty;
  assign w_pop = w_rd && (r_lane == LANE3);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop)
      w_count_nxt = r_count + CNT_ONE;
    else if (!w_wr && w_pop)
      w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && w_wr) begin
      r_mem[r_wptr] <= bus.fifo_data;
      r_tag[r_wptr] <= bus.fifo_send;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_lane       <= LANE0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_overflow   <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_word_count <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      if (w_rd)
        r_lane <= lane_t'(r_lane + 2'd1);
      if (w_rd)
        r_word_count <= r_word_count + 16'd1;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CNT_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= r_overflow || (bus.fifo_write && r_full);
      r_pkt_done <= w_pop && r_tag[r_rptr];
    end
  end

  assign bus.rd_data    = r_mem[r_rptr][{r_lane, 6'd0} +: 64];
  assign bus.fifo_full  = r_full;
  assign bus.rd_empty   = r_empty;
  assign bus.overflow   = r_overflow;
  assign bus.pkt_done   = r_pkt_done;
  assign bus.word_count = r_word_count;
endmodule
